// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM.
// Moore machine: every datapath select and enable decodes from the state register.
// The only exception is lat_cnt, which picks the cycle of a multi-cycle memory read.
// FETCH and MEM_RD each last MEM_LAT cycles; lat_cnt counts within those states.
// Unknown opcodes and unused state encodings trap into HALT and set a sticky illegal flag.
module mips_multicycle_ctrl #(
   parameter int MEM_LAT = 1,
   parameter int SRCB_W  = 3,
   parameter int ST_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        Op_code,
   output logic              MemWrite,
   output logic              IRWrite,
   output logic              MemtoReg,
   output logic              RegDst,
   output logic              RegWrite,
   output logic              ALUSrcA,
   output logic [SRCB_W-1:0] ALUSrcB,
   output logic [1:0]        ALUOp,
   output logic [1:0]        PCSource,
   output logic              PCWriteCond,
   output logic              PCWrite,
   output logic              IorD,
   output logic              illegal,
   output logic              instr_done,
   output logic [ST_W-1:0]   state_o
);

   // State encodings
   localparam logic [ST_W-1:0] S_IDLE     = ST_W'(4'd0);
   localparam logic [ST_W-1:0] S_FETCH    = ST_W'(4'd1);
   localparam logic [ST_W-1:0] S_DECODE   = ST_W'(4'd2);
   localparam logic [ST_W-1:0] S_R_EXEC   = ST_W'(4'd3);
   localparam logic [ST_W-1:0] S_R_WB     = ST_W'(4'd4);
   localparam logic [ST_W-1:0] S_MEM_ADDR = ST_W'(4'd5);
   localparam logic [ST_W-1:0] S_MEM_RD   = ST_W'(4'd6);
   localparam logic [ST_W-1:0] S_MEM_WB   = ST_W'(4'd7);
   localparam logic [ST_W-1:0] S_MEM_WR   = ST_W'(4'd8);
   localparam logic [ST_W-1:0] S_BRANCH   = ST_W'(4'd9);
   localparam logic [ST_W-1:0] S_JUMP     = ST_W'(4'd10);
   localparam logic [ST_W-1:0] S_I_EXEC   = ST_W'(4'd11);
   localparam logic [ST_W-1:0] S_I_WB     = ST_W'(4'd12);
   localparam logic [ST_W-1:0] S_HALT     = ST_W'(4'd13);

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ALUSrcB select values
   localparam logic [SRCB_W-1:0] SB_B     = SRCB_W'(3'd0);
   localparam logic [SRCB_W-1:0] SB_FOUR  = SRCB_W'(3'd1);
   localparam logic [SRCB_W-1:0] SB_SEXT  = SRCB_W'(3'd2);
   localparam logic [SRCB_W-1:0] SB_SHIFT = SRCB_W'(3'd3);

   // ALUOp and PCSource values
   localparam logic [1:0] AOP_ADD   = 2'b00;
   localparam logic [1:0] AOP_SUB   = 2'b01;
   localparam logic [1:0] AOP_FUNCT = 2'b10;
   localparam logic [1:0] PS_ALU    = 2'b00;
   localparam logic [1:0] PS_ALUOUT = 2'b01;
   localparam logic [1:0] PS_JUMP   = 2'b10;

   // Final cycle index of a memory access
   localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

   logic [ST_W-1:0] state;
   logic [ST_W-1:0] state_nxt;
   logic [3:0]      lat_cnt;
   logic [3:0]      lat_nxt;
   logic            illegal_nxt;
   logic            lat_last;

   assign lat_last = (lat_cnt == LAT_LAST);
   assign state_o  = state;

   // State, latency counter and sticky trap flag; reset aborts immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         lat_cnt <= 4'd0;
         illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         lat_cnt <= lat_nxt;
         illegal <= illegal_nxt;
      end
   end

   // Next-state, counter and trap logic; lat_cnt returns to 0 unless a read is still in progress
   always_comb begin
      state_nxt   = state;
      lat_nxt     = 4'd0;
      illegal_nxt = illegal;
      case (state)
         S_IDLE: begin
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (lat_last) begin
               state_nxt = S_DECODE;
            end else begin
               lat_nxt = lat_cnt + 4'd1;
            end
         end
         S_DECODE: begin
            case (Op_code)
               OP_RTYPE: state_nxt = S_R_EXEC;
               OP_LW:    state_nxt = S_MEM_ADDR;
               OP_SW:    state_nxt = S_MEM_ADDR;
               OP_BEQ:   state_nxt = S_BRANCH;
               OP_J:     state_nxt = S_JUMP;
               OP_ADDI:  state_nxt = S_I_EXEC;
               default: begin
                  state_nxt   = S_HALT;
                  illegal_nxt = 1'b1;
               end
            endcase
         end
         S_R_EXEC: begin
            state_nxt = S_R_WB;
         end
         S_R_WB: begin
            state_nxt = S_FETCH;
         end
         S_MEM_ADDR: begin
            // Opcode re-sampled here; anything other than LW/SW is a trap
            case (Op_code)
               OP_LW:   state_nxt = S_MEM_RD;
               OP_SW:   state_nxt = S_MEM_WR;
               default: begin
                  state_nxt   = S_HALT;
                  illegal_nxt = 1'b1;
               end
            endcase
         end
         S_MEM_RD: begin
            if (lat_last) begin
               state_nxt = S_MEM_WB;
            end else begin
               lat_nxt = lat_cnt + 4'd1;
            end
         end
         S_MEM_WB: begin
            state_nxt = S_FETCH;
         end
         S_MEM_WR: begin
            state_nxt = S_FETCH;
         end
         S_BRANCH: begin
            state_nxt = S_FETCH;
         end
         S_JUMP: begin
            state_nxt = S_FETCH;
         end
         S_I_EXEC: begin
            state_nxt = S_I_WB;
         end
         S_I_WB: begin
            state_nxt = S_FETCH;
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt   = S_HALT;
            illegal_nxt = 1'b1;
         end
      endcase
   end

   // Moore output decode; every output defaults to 0 and only listed fields are raised
   always_comb begin
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SB_B;
      ALUOp       = AOP_ADD;
      PCSource    = PS_ALU;
      PCWriteCond = 1'b0;
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      instr_done  = 1'b0;
      case (state)
         S_FETCH: begin
            ALUSrcB = SB_FOUR;
            // IR and PC load only once the read data is valid
            IRWrite = lat_last;
            PCWrite = lat_last;
         end
         S_DECODE: begin
            ALUSrcB = SB_SHIFT;
         end
         S_R_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = AOP_FUNCT;
         end
         S_R_WB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SB_SEXT;
         end
         S_MEM_RD: begin
            IorD = 1'b1;
         end
         S_MEM_WB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_WR: begin
            IorD       = 1'b1;
            MemWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = AOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PS_ALUOUT;
            instr_done  = 1'b1;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = PS_JUMP;
            instr_done = 1'b1;
         end
         S_I_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SB_SEXT;
         end
         S_I_WB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         default: begin
            MemWrite = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: two instances (MEM_LAT=1 and MEM_LAT=3)
// share clock, reset and opcode. Expected per-cycle output vectors are queued per instruction
// and compared on the falling clock edge.
module tb_mips_multicycle_ctrl;

   logic       clk;
   logic       rst;
   logic [5:0] Op_code;

   logic       mw1, irw1, m2r1, rd1, rw1, sa1, pwc1, pw1, iord1, ill1, done1;
   logic [2:0] sb1;
   logic [1:0] ao1, ps1;
   logic [3:0] st1;
   logic       mw3, irw3, m2r3, rd3, rw3, sa3, pwc3, pw3, iord3, ill3, done3;
   logic [2:0] sb3;
   logic [1:0] ao3, ps3;
   logic [3:0] st3;

   logic [21:0] obs1, obs3;
   logic [21:0] sb_q[$];

   int checks = 0;
   int errors = 0;

   localparam logic Z = 1'b0;
   localparam logic H = 1'b1;

   mips_multicycle_ctrl #(.MEM_LAT(1), .SRCB_W(3), .ST_W(4)) dut1 (
      .clk(clk), .rst(rst), .Op_code(Op_code),
      .MemWrite(mw1), .IRWrite(irw1), .MemtoReg(m2r1), .RegDst(rd1), .RegWrite(rw1),
      .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(ao1), .PCSource(ps1), .PCWriteCond(pwc1),
      .PCWrite(pw1), .IorD(iord1), .illegal(ill1), .instr_done(done1), .state_o(st1)
   );

   mips_multicycle_ctrl #(.MEM_LAT(3), .SRCB_W(3), .ST_W(4)) dut3 (
      .clk(clk), .rst(rst), .Op_code(Op_code),
      .MemWrite(mw3), .IRWrite(irw3), .MemtoReg(m2r3), .RegDst(rd3), .RegWrite(rw3),
      .ALUSrcA(sa3), .ALUSrcB(sb3), .ALUOp(ao3), .PCSource(ps3), .PCWriteCond(pwc3),
      .PCWrite(pw3), .IorD(iord3), .illegal(ill3), .instr_done(done3), .state_o(st3)
   );

   assign obs1 = {st1, mw1, irw1, m2r1, rd1, rw1, sa1, sb1, ao1, ps1, pwc1, pw1, iord1, done1, ill1};
   assign obs3 = {st3, mw3, irw3, m2r3, rd3, rw3, sa3, sb3, ao3, ps3, pwc3, pw3, iord3, done3, ill3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack an expected output vector in the same field order as obs1/obs3
   function automatic logic [21:0] ev(input logic [3:0] st, input logic [2:0] srcb,
                                      input logic [1:0] aop, input logic [1:0] psrc,
                                      input logic srca, input logic memw, input logic irw,
                                      input logic m2r, input logic rdst, input logic rw,
                                      input logic pwc, input logic pw, input logic iord,
                                      input logic done, input logic ill);
      return {st, memw, irw, m2r, rdst, rw, srca, srcb, aop, psrc, pwc, pw, iord, done, ill};
   endfunction

   task automatic push_fetch(input int lat);
      for (int k = 0; k < lat; k++) begin
         logic last;
         last = (k == lat - 1);
         sb_q.push_back(ev(4'd1, 3'b001, 2'b00, 2'b00, Z, Z, last, Z, Z, Z, Z, last, Z, Z, Z));
      end
   endtask

   task automatic push_decode();
      sb_q.push_back(ev(4'd2, 3'b011, 2'b00, 2'b00, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z));
   endtask

   task automatic push_halt(input int n);
      for (int k = 0; k < n; k++) begin
         sb_q.push_back(ev(4'd13, 3'b000, 2'b00, 2'b00, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, H));
      end
   endtask

   // Queue the full expected cycle trace of one legal instruction
   task automatic push_instr(input logic [5:0] op, input int lat);
      push_fetch(lat);
      push_decode();
      case (op)
         6'b000000: begin
            sb_q.push_back(ev(4'd3, 3'b000, 2'b10, 2'b00, H, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z));
            sb_q.push_back(ev(4'd4, 3'b000, 2'b00, 2'b00, Z, Z, Z, Z, H, H, Z, Z, Z, H, Z));
         end
         6'b100011: begin
            sb_q.push_back(ev(4'd5, 3'b010, 2'b00, 2'b00, H, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z));
            for (int k = 0; k < lat; k++)
               sb_q.push_back(ev(4'd6, 3'b000, 2'b00, 2'b00, Z, Z, Z, Z, Z, Z, Z, Z, H, Z, Z));
            sb_q.push_back(ev(4'd7, 3'b000, 2'b00, 2'b00, Z, Z, Z, H, Z, H, Z, Z, Z, H, Z));
         end
         6'b101011: begin
            sb_q.push_back(ev(4'd5, 3'b010, 2'b00, 2'b00, H, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z));
            sb_q.push_back(ev(4'd8, 3'b000, 2'b00, 2'b00, Z, H, Z, Z, Z, Z, Z, Z, H, H, Z));
         end
         6'b000100: begin
            sb_q.push_back(ev(4'd9, 3'b000, 2'b01, 2'b01, H, Z, Z, Z, Z, Z, H, Z, Z, H, Z));
         end
         6'b000010: begin
            sb_q.push_back(ev(4'd10, 3'b000, 2'b00, 2'b10, Z, Z, Z, Z, Z, Z, Z, H, Z, H, Z));
         end
         6'b001000: begin
            sb_q.push_back(ev(4'd11, 3'b010, 2'b00, 2'b00, H, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z));
            sb_q.push_back(ev(4'd12, 3'b000, 2'b00, 2'b00, Z, Z, Z, Z, Z, H, Z, Z, Z, H, Z));
         end
         default: begin
            push_halt(1);
         end
      endcase
   endtask

   // Drain the scoreboard, one entry per cycle, against the selected instance
   task automatic run_dut(input bit use3, input string name);
      int n = 0;
      while (sb_q.size() > 0) begin
         logic [21:0] e;
         logic [21:0] o;
         @(negedge clk);
         e = sb_q.pop_front();
         o = use3 ? obs3 : obs1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h (state %0d) expected %h (state %0d)",
                     name, n, o, o[21:18], e, e[21:18]);
         end
         n++;
      end
   endtask

   // Assert reset for two cycles and release on a falling edge; DUTs sit in IDLE afterwards
   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (obs1 !== 22'd0) begin
            errors++;
            $display("FAIL reset_l1: got %h expected %h", obs1, 22'd0);
         end
         checks++;
         if (obs3 !== 22'd0) begin
            errors++;
            $display("FAIL reset_l3: got %h expected %h", obs3, 22'd0);
         end
      end
      rst = 1'b1;
      Op_code = 6'b000000;
      push_fetch(1);
      run_dut(1'b0, "reset_release_fetch");
   endtask

   task automatic test_rtype();
      do_reset();
      Op_code = 6'b000000;
      push_instr(6'b000000, 1);
      push_instr(6'b000000, 1);
      run_dut(1'b0, "rtype_l1");
   endtask

   task automatic test_lw_lat3();
      do_reset();
      Op_code = 6'b100011;
      push_instr(6'b100011, 3);
      checks++;
      if (sb_q.size() != 9) begin
         errors++;
         $display("FAIL lw_l3_length: got %0d expected %0d", sb_q.size(), 9);
      end
      run_dut(1'b1, "lw_l3");
   endtask

   task automatic test_beq_j();
      do_reset();
      Op_code = 6'b000100;
      push_instr(6'b000100, 1);
      run_dut(1'b0, "beq_l1");
      Op_code = 6'b000010;
      push_instr(6'b000010, 1);
      run_dut(1'b0, "j_l1");
   endtask

   task automatic test_sw_addi();
      do_reset();
      Op_code = 6'b101011;
      push_instr(6'b101011, 1);
      run_dut(1'b0, "sw_l1");
      Op_code = 6'b001000;
      push_instr(6'b001000, 1);
      run_dut(1'b0, "addi_l1");
   endtask

   task automatic test_illegal();
      do_reset();
      Op_code = 6'b111111;
      push_fetch(1);
      push_decode();
      push_halt(20);
      run_dut(1'b0, "illegal_halt");
      #2 rst = 1'b0;
      #1;
      checks++;
      if (ill1 !== 1'b0 || st1 !== 4'd0) begin
         errors++;
         $display("FAIL illegal_clear_l1: got ill=%b st=%0d expected ill=0 st=0", ill1, st1);
      end
      checks++;
      if (ill3 !== 1'b0 || st3 !== 4'd0) begin
         errors++;
         $display("FAIL illegal_clear_l3: got ill=%b st=%0d expected ill=0 st=0", ill3, st3);
      end
   endtask

   task automatic test_sw_reset();
      do_reset();
      Op_code = 6'b101011;
      push_instr(6'b101011, 1);
      run_dut(1'b0, "sw_before_reset");
      // The last compared cycle was MEM_WR with MemWrite high; pull reset mid-cycle
      #2 rst = 1'b0;
      #1;
      checks++;
      if (mw1 !== 1'b0 || st1 !== 4'd0) begin
         errors++;
         $display("FAIL sw_reset_abort: got mw=%b st=%0d expected mw=0 st=0", mw1, st1);
      end
      checks++;
      if (obs1 !== 22'd0) begin
         errors++;
         $display("FAIL sw_reset_outputs: got %h expected %h", obs1, 22'd0);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [6];
      ops[0] = 6'b000000; ops[1] = 6'b101011; ops[2] = 6'b000100;
      ops[3] = 6'b000010; ops[4] = 6'b001000; ops[5] = 6'b100011;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         Op_code = ops[i];
         push_instr(ops[i], 1);
         run_dut(1'b0, "b2b_l1");
      end
      do_reset();
      for (int i = 0; i < 6; i++) begin
         Op_code = ops[5 - i];
         push_instr(ops[5 - i], 3);
         run_dut(1'b1, "b2b_l3");
      end
   endtask

   initial begin
      rst = 1'b1;
      Op_code = 6'b000000;
      #1;
      test_reset();
      test_rtype();
      test_lw_lat3();
      test_beq_j();
      test_sw_addi();
      test_illegal();
      test_sw_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
